// File: rtl/zuart_pkg.sv
// Shared definitions for the UART packet framer: state encoding, sync-byte defaults and CRC-8 polynomial.
package zuart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H0,
        ST_H1,
        ST_CMD,
        ST_LEN,
        ST_PAY,
        ST_CHK,
        ST_DONE
    } state_t;

    localparam logic [7:0] HDR0_DEF  = 8'hAA;
    localparam logic [7:0] HDR1_DEF  = 8'h55;
    localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/zuart_crc8_byte.sv
// Combinational CRC-8 (MSB-first, unreflected) advance by one data byte, unrolled over 8 bit steps.
module zuart_crc8_byte
    import zuart_pkg::*;
(
    input  logic [7:0] crcIn,
    input  logic [7:0] dataIn,
    output logic [7:0] crcOut
);

    logic [7:0] crc;

    always_comb begin
        crc = crcIn ^ dataIn;
        for (int i = 0; i < 8; i++) begin
            crc = crc[7] ? ((crc << 1) ^ CRC8_POLY) : (crc << 1);
        end
    end

    assign crcOut = crc;

endmodule

// File: rtl/zuart_pkt_framer.sv
// Frames CMD + payload as AA 55 CMD LEN PAYLOAD.. CHK into the Tx FIFO write port.
// Define ZUART_FRAMER_CRC8_EN to make CHK a CRC-8 instead of the additive sum.
//
// state   | meaning
// IDLE    | waiting for iSend with iEn high
// H0      | presenting first sync byte
// H1      | presenting second sync byte
// CMD     | presenting latched command byte
// LEN     | presenting payload length
// PAY     | presenting payload bytes, MSB first
// CHK     | presenting checksum / CRC
// DONE    | one-cycle oDone pulse, then IDLE
module zuart_pkt_framer
    import zuart_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] HDR0          = HDR0_DEF,
    parameter logic [7:0] HDR1          = HDR1_DEF
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iEn,
    input  logic                       iSend,
    input  logic [7:0]                 iCmd,
    input  logic [8*PAYLOAD_BYTES-1:0] iPayload,
    output logic                       oBusy,
    output logic                       oDone,
    output logic                       oWrEn,
    output logic [7:0]                 oWrData,
    input  logic                       iFull
);

    localparam int         PayW    = 8 * PAYLOAD_BYTES;
    localparam logic [7:0] LenByte = 8'(PAYLOAD_BYTES);
    localparam logic [7:0] LastIdx = 8'(PAYLOAD_BYTES - 1);

    state_t          state;
    logic [7:0]      cmdReg;
    logic [7:0]      chkReg;
    logic [7:0]      chkNext;
    logic [7:0]      byteCnt;
    logic [7:0]      curByte;
    logic [PayW-1:0] payShift;
    logic            emitting;
    logic            covered;
    logic            consume;

    // Outgoing byte is a pure function of registered state, so it is stable across stalls.
    always_comb begin
        curByte = 8'h00;
        case (state)
            ST_H0:   curByte = HDR0;
            ST_H1:   curByte = HDR1;
            ST_CMD:  curByte = cmdReg;
            ST_LEN:  curByte = LenByte;
            ST_PAY:  curByte = payShift[PayW-1 -: 8];
            ST_CHK:  curByte = chkReg;
            default: curByte = 8'h00;
        endcase
    end

    assign emitting = (state inside {ST_H0, ST_H1, ST_CMD, ST_LEN, ST_PAY, ST_CHK});
    assign covered  = (state inside {ST_CMD, ST_LEN, ST_PAY});
    assign consume  = emitting && iEn && !iFull;
    assign oWrEn    = consume;
    assign oWrData  = curByte;

`ifdef ZUART_FRAMER_CRC8_EN
    zuart_crc8_byte uCrc (
        .crcIn  (chkReg),
        .dataIn (curByte),
        .crcOut (chkNext)
    );
`else
    assign chkNext = chkReg + curByte;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= ST_IDLE;
            cmdReg   <= 8'h00;
            chkReg   <= 8'h00;
            byteCnt  <= 8'h00;
            payShift <= '0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iEn && iSend) begin
                        cmdReg   <= iCmd;
                        payShift <= iPayload;
                        chkReg   <= 8'h00;
                        byteCnt  <= 8'h00;
                        oBusy    <= 1'b1;
                        state    <= ST_H0;
                    end
                end
                ST_H0:  if (consume) state <= ST_H1;
                ST_H1:  if (consume) state <= ST_CMD;
                ST_CMD: if (consume) state <= ST_LEN;
                ST_LEN: if (consume) state <= ST_PAY;
                ST_PAY: begin
                    if (consume) begin
                        payShift <= payShift << 8;
                        if (byteCnt == LastIdx) begin
                            byteCnt <= 8'h00;
                            state   <= ST_CHK;
                        end else begin
                            byteCnt <= byteCnt + 8'h01;
                        end
                    end
                end
                ST_CHK: begin
                    if (consume) begin
                        oDone <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    oBusy <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (consume && covered) chkReg <= chkNext;
        end
    end

endmodule

// File: tb/tb_zuart_pkt_framer.sv
// Scoreboard bench for zuart_pkt_framer; CHK model follows ZUART_FRAMER_CRC8_EN.
module tb_zuart_pkt_framer;

    localparam int N = 4;

    logic          iClk;
    logic          iRst;
    logic          iEn;
    logic          iSend;
    logic [7:0]    iCmd;
    logic [8*N-1:0] iPayload;
    logic          oBusy;
    logic          oDone;
    logic          oWrEn;
    logic [7:0]    oWrData;
    logic          iFull;

    int checks = 0;
    int passes = 0;
    int writeCnt = 0;
    int doneCnt = 0;
    logic [7:0] expQ[$];
    logic [7:0] expByte;

    zuart_pkt_framer #(.PAYLOAD_BYTES(N)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEn      (iEn),
        .iSend    (iSend),
        .iCmd     (iCmd),
        .iPayload (iPayload),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oWrEn    (oWrEn),
        .oWrData  (oWrData),
        .iFull    (iFull)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Bitwise reference: sum, or CRC-8 poly 0x07 shifted one data bit at a time.
    function automatic logic [7:0] chkModel(input logic [7:0] acc, input logic [7:0] d);
`ifdef ZUART_FRAMER_CRC8_EN
        logic [7:0] c;
        logic fb;
        c = acc;
        for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ d[b];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
`else
        return acc + d;
`endif
    endfunction

    task automatic pushFrame(input logic [7:0] cmd, input logic [8*N-1:0] pay);
        logic [7:0] acc;
        logic [7:0] pb;
        acc = 8'h00;
        expQ.push_back(8'hAA);
        expQ.push_back(8'h55);
        expQ.push_back(cmd);
        acc = chkModel(acc, cmd);
        expQ.push_back(8'(N));
        acc = chkModel(acc, 8'(N));
        for (int i = 0; i < N; i++) begin
            pb = pay[8*(N-1-i) +: 8];
            expQ.push_back(pb);
            acc = chkModel(acc, pb);
        end
        expQ.push_back(acc);
    endtask

    // Returns one cycle after the accepting edge (just after that edge).
    task automatic sendFrame(input logic [7:0] cmd, input logic [8*N-1:0] pay);
        @(posedge iClk); #1;
        iCmd = cmd;
        iPayload = pay;
        iSend = 1'b1;
        @(posedge iClk); #1;
        iSend = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (n < budget && !seen) begin
            @(negedge iClk);
            n++;
            if (oDone === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) $display("FAIL done_timeout: oDone not seen within %0d cycles", budget);
        else passes++;
        checks++;
        if (expQ.size() != 0) $display("FAIL frame_incomplete: %0d bytes still expected, required 0", expQ.size());
        else passes++;
    endtask

    always @(negedge iClk) begin
        if (!iRst) begin
            if (oWrEn === 1'b1) begin
                writeCnt++;
                checks++;
                if (expQ.size() == 0) begin
                    $display("FAIL unexpected_write: got %02h, required no write", oWrData);
                end else begin
                    expByte = expQ.pop_front();
                    if (oWrData !== expByte)
                        $display("FAIL wr_data: got %02h, required %02h", oWrData, expByte);
                    else passes++;
                end
            end
            if (iEn === 1'b0) begin
                checks++;
                if (oWrEn !== 1'b0) $display("FAIL write_while_disabled: oWrEn=%b, required 0", oWrEn);
                else passes++;
            end
            if (oDone === 1'b1) doneCnt++;
        end
    end

    task automatic test_reset();
        #2;
        checks++;
        if (oBusy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", oBusy); else passes++;
        checks++;
        if (oDone !== 1'b0) $display("FAIL rst_done: got %b, required 0", oDone); else passes++;
        checks++;
        if (oWrEn !== 1'b0) $display("FAIL rst_wren: got %b, required 0", oWrEn); else passes++;
        checks++;
        if (oWrData !== 8'h00) $display("FAIL rst_wrdata: got %02h, required 00", oWrData); else passes++;
        @(negedge iClk);
        iRst = 1'b0;
        repeat (2) @(negedge iClk);
    endtask

    task automatic test_basic();
        pushFrame(8'h10, 32'h01020304);
        sendFrame(8'h10, 32'h01020304);
        for (int i = 0; i < 5 + N; i++) begin
            @(negedge iClk);
            checks++;
            if (oWrEn !== 1'b1 || oBusy !== 1'b1)
                $display("FAIL basic_consecutive: cycle %0d wren=%b busy=%b, required 1 1", i, oWrEn, oBusy);
            else passes++;
        end
        @(negedge iClk);
        checks++;
        if (oDone !== 1'b1 || oBusy !== 1'b1 || oWrEn !== 1'b0)
            $display("FAIL basic_done: done=%b busy=%b wren=%b, required 1 1 0", oDone, oBusy, oWrEn);
        else passes++;
        @(negedge iClk);
        checks++;
        if (oDone !== 1'b0 || oBusy !== 1'b0)
            $display("FAIL basic_idle: done=%b busy=%b, required 0 0", oDone, oBusy);
        else passes++;
        checks++;
        if (expQ.size() != 0) $display("FAIL basic_frame_left: %0d bytes pending, required 0", expQ.size());
        else passes++;
    endtask

    task automatic test_backpressure();
        pushFrame(8'h10, 32'h01020304);
        sendFrame(8'h10, 32'h01020304);
        repeat (5) @(posedge iClk);
        #1 iFull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            checks++;
            if (oWrEn !== 1'b0 || oWrData !== 8'h02)
                $display("FAIL bp_hold: cycle %0d wren=%b data=%02h, required 0 02", i, oWrEn, oWrData);
            else passes++;
            @(posedge iClk);
        end
        #1 iFull = 1'b0;
        waitDone(30);
    endtask

    task automatic test_wrap();
        pushFrame(8'hFF, 32'hFFFFFFFF);
        sendFrame(8'hFF, 32'hFFFFFFFF);
        waitDone(30);
        repeat (2) @(negedge iClk);
    endtask

    task automatic test_busy_pause();
        int w0;
        int d0;
        d0 = doneCnt;
        pushFrame(8'h22, 32'hA1B2C3D4);
        sendFrame(8'h22, 32'hA1B2C3D4);
        @(posedge iClk); #1;
        iCmd = 8'h99;
        iPayload = 32'h55667788;
        iSend = 1'b1;
        @(posedge iClk); #1;
        iSend = 1'b0;
        repeat (3) @(posedge iClk);
        #1 iEn = 1'b0;
        repeat (5) @(posedge iClk);
        checks++;
        if (oBusy !== 1'b1) $display("FAIL pause_busy: got %b, required 1", oBusy); else passes++;
        #1 iEn = 1'b1;
        waitDone(40);
        w0 = writeCnt;
        repeat (6) @(negedge iClk);
        checks++;
        if (writeCnt != w0 || oBusy !== 1'b0)
            $display("FAIL busy_ignored: extra writes=%0d busy=%b, required 0 0", writeCnt - w0, oBusy);
        else passes++;
        checks++;
        if (doneCnt - d0 != 1) $display("FAIL busy_done_count: got %0d, required 1", doneCnt - d0);
        else passes++;
    endtask

    task automatic test_idle_disabled();
        int w0;
        w0 = writeCnt;
        @(posedge iClk); #1;
        iEn = 1'b0;
        iSend = 1'b1;
        repeat (3) @(posedge iClk);
        #1 iSend = 1'b0;
        @(negedge iClk);
        checks++;
        if (oBusy !== 1'b0 || writeCnt != w0)
            $display("FAIL idle_disabled: busy=%b writes=%0d, required 0 0", oBusy, writeCnt - w0);
        else passes++;
        iEn = 1'b1;
        repeat (3) @(negedge iClk);
        checks++;
        if (oBusy !== 1'b0) $display("FAIL idle_disabled_late: busy=%b, required 0", oBusy); else passes++;
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = doneCnt;
        pushFrame(8'h10, 32'h01020304);
        sendFrame(8'h10, 32'h01020304);
        repeat (3) @(posedge iClk);
        #3 iRst = 1'b1;
        #1;
        checks++;
        if (oBusy !== 1'b0 || oDone !== 1'b0 || oWrEn !== 1'b0 || oWrData !== 8'h00)
            $display("FAIL mid_reset_outputs: busy=%b done=%b wren=%b data=%02h, required 0 0 0 00",
                     oBusy, oDone, oWrEn, oWrData);
        else passes++;
        checks++;
        if (expQ.size() != 2 + N) $display("FAIL mid_reset_progress: %0d bytes pending, required %0d", expQ.size(), 2 + N);
        else passes++;
        expQ.delete();
        @(negedge iClk);
        iRst = 1'b0;
        repeat (12) @(negedge iClk);
        checks++;
        if (doneCnt != d0 || oBusy !== 1'b0)
            $display("FAIL mid_reset_no_done: done pulses=%0d busy=%b, required 0 0", doneCnt - d0, oBusy);
        else passes++;
        pushFrame(8'h3C, 32'h0BADF00D);
        sendFrame(8'h3C, 32'h0BADF00D);
        waitDone(30);
    endtask

    initial begin
        iRst = 1'b1;
        iEn = 1'b1;
        iSend = 1'b0;
        iFull = 1'b0;
        iCmd = 8'h00;
        iPayload = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_busy_pause();
        test_idle_disabled();
        test_reset_mid();
        repeat (3) @(negedge iClk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/zuart_pkt_framer.md
Name: zuart_pkt_framer

Overview:
- Packet framer sitting directly upstream of the UART Tx-with-FIFO stage; drives that stage's FIFO write interface (write enable, data, full).
- Accepts one command byte plus a fixed-size payload word and emits one framed packet byte-by-byte into the Tx FIFO, respecting full back-pressure.
- Frame layout: 0xAA, 0x55, CMD, LEN, PAYLOAD[0..N-1] (most significant byte first), CHK.

Parameters:
- PAYLOAD_BYTES, 4: payload length N in bytes, 1..255; LEN field = N.
- HDR0, 8'hAA: first sync byte.
- HDR1, 8'h55: second sync byte.

Ports:
- iClk  input  1  system clock.
- iRst  input  1  asynchronous, active-high reset.
- iEn  input  1  block enable; low = pause (hold state, no writes).
- iSend  input  1  request to send one frame; sampled in IDLE only.
- iCmd  input  8  command byte, latched on accept.
- iPayload  input  8*PAYLOAD_BYTES  payload, latched on accept; byte 0 = bits [8N-1:8N-8].
- oBusy  output  1  high from accept until oDone cycle inclusive.
- oDone  output  1  one-cycle pulse after CHK byte written.
- oWrEn  output  1  FIFO write strobe, one byte per cycle max.
- oWrData  output  8  FIFO write data, valid when oWrEn high.
- iFull  input  1  FIFO full flag from Tx FIFO.

Behaviour:
- Reset (iRst high, async): state IDLE, oBusy=0, oDone=0, oWrEn=0, oWrData=8'h00, byte counter=0, checksum=0, latches cleared.
- States: IDLE -> H0 -> H1 -> CMD -> LEN -> PAY -> CHK -> DONE -> IDLE.
- IDLE: if iEn && iSend: latch iCmd/iPayload, clear checksum, oBusy=1, go H0 (accept cycle; no write this cycle). iSend while not IDLE ignored; no queuing.
- Emit states (H0..CHK): oWrData is the state's byte; oWrEn = iEn && !iFull (combinational from registered state/data and iFull). A byte is consumed only in a cycle with oWrEn=1; state advances on that edge. iFull high or iEn low: hold state, byte, counter, checksum unchanged.
- PAY: counter 0..N-1 selects payload byte; advance to CHK after byte N-1 written; counter wraps to 0.
- Checksum: 8-bit sum mod 256 of CMD, LEN, all payload bytes (headers excluded); updated on each consumed covered byte; CHK byte = final sum.
- DONE: oDone=1 for exactly one cycle, oBusy still 1; next cycle IDLE, oBusy=0. New frame acceptable the cycle after DONE.
- Minimum latency: accept edge to first oWrEn = 1 cycle; full frame = 5+N write cycles with iFull low.
- iFull asserting mid-frame: stall indefinitely, no byte dropped or duplicated.
- Reset mid-frame: abort immediately; bytes already in FIFO not recalled; no oDone.
- iEn low in IDLE: iSend ignored.

Optional Feature:
- Macro ZUART_FRAMER_CRC8_EN.
- Defined: CHK = CRC-8, poly 0x07, init 0x00, MSB-first, no reflection, no final XOR, over CMD, LEN, payload; one byte per cycle (8 unrolled steps).
- Undefined: CHK = 8-bit additive sum as above. Frame length and timing are identical in both builds.

Decomposition:
- Shared package zuart_pkg: state encoding constants, HDR0/HDR1 defaults, CRC8_POLY=8'h07.
- One natural sub-module: zuart_crc8_byte (combinational next-CRC from current CRC + data byte), instantiated only under ZUART_FRAMER_CRC8_EN.

Test Plan:
- Basic frame, iFull=0, N=4, iCmd=0x10, iPayload=0x01020304 -> writes AA 55 10 04 01 02 03 04 1E on 9 consecutive cycles; oDone pulses the cycle after 0x1E.
- Back-pressure: same frame, iFull high for 3 cycles while byte 0x02 is presented -> 0x02 held, written exactly once; frame bytes unchanged.
- Checksum wrap: iCmd=0xFF, iPayload=0xFFFFFFFF -> CHK = (0xFF+0x04+4*0xFF) mod 256 = 0xFF.
- iSend pulsed while busy, plus iEn dropped for 5 cycles mid-payload -> one frame only, no writes while iEn=0, correct bytes afterward.
- iRst asserted after 0x10 written -> all outputs 0 asynchronously, no oDone; new iSend after reset yields a full frame.
- CRC build (ZUART_FRAMER_CRC8_EN): basic frame -> CHK equals bench CRC-8 model over 10 04 01 02 03 04; all other bytes identical to the sum build.
